ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have one clock, clk; reset is rst_n, synchronous and active-low.
REQ-002 The block SHALL have no parameters; the datapath is fixed at 32 bits.
REQ-003 The block SHALL have these ports:
  clk      in   1   pipeline clock, all state changes on rising edge
  rst_n    in   1   synchronous active-low reset
  start    in   1   begin operation selected by op using EX_rd1/EX_rd2
  op       in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
  EX_rd1   in   32  operand A / dividend, from ID/EX register
  EX_rd2   in   32  operand B / divisor, from ID/EX register
  mthi     in   1   write EX_rd1 into hi
  mtlo     in   1   write EX_rd1 into lo
  busy     out  1   operation in progress; hazard logic stalls IF/ID and ID/EX while high
  done     out  1   one-cycle pulse, hi/lo hold a new result
  hi       out  32  HI register: product[63:32] / remainder
  lo       out  32  LO register: product[31:0] / quotient

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE; busy = (state==RUN) and done = (state==DONE), both registered-state decodes.
REQ-005 In IDLE or DONE, start=1 on edge E0 SHALL latch op and the operand magnitudes, clear the 5-bit iteration counter, and enter RUN.
REQ-006 In RUN, the block SHALL perform one radix-2 iteration per edge: shift-add for multiply, restoring shift-subtract for divide.
REQ-007 On the edge where the counter is 31 (E32), the block SHALL apply sign fix-up, write hi/lo and enter DONE.
REQ-008 DONE SHALL last exactly one cycle and then return to IDLE, unless start is asserted during DONE (REQ-005).
REQ-009 MULT/DIV SHALL treat operands as two's complement; MULTU/DIVU SHALL treat them as unsigned.
REQ-010 Signed divide SHALL truncate the quotient toward zero; the remainder SHALL take the dividend's sign.
REQ-011 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no exception.
REQ-012 Divide with EX_rd2==0 at start SHALL skip RUN: DONE at E1, hi=EX_rd1, lo=0xFFFFFFFF, for both signed and unsigned divide.
REQ-013 Multiply SHALL produce the full 64-bit product: hi=[63:32], lo=[31:0].
REQ-014 start SHALL be ignored while in RUN.
REQ-015 mthi/mtlo SHALL be ignored while in RUN.
REQ-016 When start and mthi/mtlo are asserted on the same edge in IDLE/DONE, start SHALL win and mthi/mtlo SHALL be ignored.
REQ-017 When mthi and mtlo are both asserted with no start, both registers SHALL load EX_rd1 on the same edge.
REQ-018 hi/lo SHALL change only at E32 (or E1 for divide-by-zero), on an mthi/mtlo write, or on reset; intermediate iteration state SHALL be held internally and SHALL NOT be visible on hi/lo.
REQ-019 Operands SHALL be latched at E0; changes on EX_rd1/EX_rd2 during RUN SHALL NOT affect the result.

Reset
REQ-020 On rst_n=0 at an edge: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
REQ-021 Reset SHALL have priority over start, mthi and mtlo.
REQ-022 Reset asserted during RUN SHALL abort the operation, and done SHALL NOT pulse for it.
REQ-023 Outputs SHALL be defined (not X) from the first edge with rst_n=0.

Verification
REQ-024 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high for 32 cycles, then done=1 for 1 cycle, hi=0xFFFFFFFE, lo=0x00000001.
REQ-025 MULT 0xFFFFFFFD x 0x00000007 (-3 x 7) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-026 DIV 0xFFFFFFF9 / 0x00000002 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-026 also covers DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-027 DIVU 5 / 0 -> busy never high, done pulses the cycle after E1, hi=5, lo=0xFFFFFFFF.
REQ-028 Start MULTU 2x3, then pulse start with a DIVU op and pulse mthi=0xAAAA during RUN -> both ignored; hi=0, lo=6 at done.
REQ-028 also covers rst_n=0 at RUN cycle 10 -> busy=0, hi=lo=0, no done pulse.
REQ-029 DONE followed immediately by start -> a second result lands exactly 32 cycles later with no idle gap.
REQ-029 also covers start+mthi on the same edge in IDLE -> hi is not written with EX_rd1.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative 32-bit multiply/divide unit with HI/LO result registers.
// Signed and unsigned multiply use radix-2 shift-add. Signed and unsigned
// divide use restoring shift-subtract. Each operation takes 32 iterations,
// and the signs are fixed up on the final edge.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] EX_rd1,
  input  logic [31:0] EX_rd2,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        dz_pend;
  logic        is_div_q, neg_q, neg_r;
  logic [31:0] opnd, w_hi, w_lo;

  // Conditional two's-complement negation used for the final sign fix-up
  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic n);
    return n ? (~v + 64'd1) : v;
  endfunction

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

  // Operand magnitudes and signs taken from the ID/EX operands at start
  logic signed [31:0] rd1_s, rd2_s;
  logic               sa, sb, dz_start, start_ok;
  logic [31:0]        a_mag, b_mag;

  assign rd1_s    = EX_rd1;
  assign rd2_s    = EX_rd2;
  assign sa       = ~op[0] & rd1_s[31];
  assign sb       = ~op[0] & rd2_s[31];
  assign a_mag    = sa ? (~EX_rd1 + 32'd1) : EX_rd1;
  assign b_mag    = sb ? (~EX_rd2 + 32'd1) : EX_rd2;
  assign dz_start = op[1] & (EX_rd2 == 32'd0);
  assign start_ok = start & (state != RUN) & ~dz_pend;

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
  logic [32:0] m_sum, d_sh;
  logic [31:0] d_diff, it_hi, it_lo;
  logic        d_ge;

  always_comb begin
    m_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opnd} : 33'd0);
    d_sh   = {w_hi, w_lo[31]};
    d_ge   = (d_sh >= {1'b0, opnd});
    d_diff = d_sh[31:0] - opnd;
    if (is_div_q) begin
      it_hi = d_ge ? d_diff : d_sh[31:0];
      it_lo = {w_lo[30:0], d_ge};
    end else begin
      it_hi = m_sum[32:1];
      it_lo = {m_sum[0], w_lo[31:1]};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a zero-divisor divide waits one cycle in IDLE and then goes straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dz_pend)                   state_nxt = DONE;
        else if (start && !dz_start)   state_nxt = RUN;
      end
      RUN: begin
        if (cnt == 5'd31)              state_nxt = DONE;
      end
      DONE: begin
        if (start && !dz_start)        state_nxt = RUN;
        else                           state_nxt = IDLE;
      end
      default:                         state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Control and architectural HI/LO: iteration count, divide-by-zero pending, result and mthi/mtlo writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= 5'd0;
      dz_pend <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (state == RUN) begin
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        if (is_div_q) begin
          lo <= cond_neg32(it_lo, neg_q);
          hi <= cond_neg32(it_hi, neg_r);
        end else begin
          {hi, lo} <= cond_neg64({it_hi, it_lo}, neg_q);
        end
      end
    end else if (dz_pend) begin
      hi      <= w_lo;
      lo      <= 32'hFFFF_FFFF;
      dz_pend <= 1'b0;
    end else if (start) begin
      cnt     <= 5'd0;
      dz_pend <= dz_start;
    end else begin
      if (mthi) hi <= EX_rd1;
      if (mtlo) lo <= EX_rd1;
    end
  end

  // Working datapath: operands are captured at start, then advanced one step per RUN cycle
  always_ff @(posedge clk) begin
    if (state == RUN) begin
      w_hi <= it_hi;
      w_lo <= it_lo;
    end else if (start_ok) begin
      is_div_q <= op[1];
      neg_q    <= sa ^ sb;
      neg_r    <= sa;
      opnd     <= op[1] ? b_mag : a_mag;
      w_hi     <= 32'd0;
      w_lo     <= dz_start ? EX_rd1 : (op[1] ? a_mag : b_mag);
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: table-driven vectors, randomized operations against an
// arithmetic reference model, and hand-written multi-cycle sequences.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] EX_rd1 = 32'd0;
  logic [31:0] EX_rd2 = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .EX_rd1(EX_rd1), .EX_rd2(EX_rd2), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic. SV division truncates toward zero,
  // and % gives the dividend's sign.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    eh = 32'd0;
    el = 32'd0;
    case (o)
      2'd0: begin p = sa * sb; {eh, el} = p; end
      2'd1: begin up = ua * ub; {eh, el} = up; end
      default: begin
        if (b == 32'd0) begin
          eh = a;
          el = 32'hFFFF_FFFF;
        end else if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          el = q[31:0];
          eh = r[31:0];
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          el = uq[31:0];
          eh = ur[31:0];
        end
      end
    endcase
  endfunction

  task automatic wait_done(output int cyc, output int nb, input bit scramble);
    cyc = 0;
    nb  = 0;
    while (!done && cyc < 100) begin
      if (busy) nb++;
      if (scramble) begin
        EX_rd1 = $urandom;
        EX_rd2 = $urandom;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat, input bit scramble);
    int cyc, nb;
    @(negedge clk);
    op = o; EX_rd1 = a; EX_rd2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, nb, scramble);
    chk({name, " latency"}, cyc, elat);
    chk({name, " busy_cycles"}, nb, (elat == 1) ? 0 : 32);
    chk({name, " hi"}, hi, ehi);
    chk({name, " lo"}, lo, elo);
    @(negedge clk);
    chk({name, " done_one_cycle"}, done, 1'b0);
  endtask

  initial begin
    int          cyc, nb, ndone;
    logic [1:0]  o;
    logic [31:0] a, b, eh, el;

    tbl[0]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32};
    tbl[1]  = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32};
    tbl[2]  = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32};
    tbl[3]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32};
    tbl[4]  = '{2'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1};
    tbl[5]  = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 32};
    tbl[6]  = '{2'd2, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1};
    tbl[7]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 32};
    tbl[8]  = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32};
    tbl[9]  = '{2'd1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32};
    tbl[10] = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        32};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].ehi, tbl[i].elo,
             tbl[i].lat, 1'b0);

    // Random operations against the model, operands scrambled during RUN
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      model(o, a, b, eh, el);
      run_op($sformatf("rnd%0d op%0d %h %h", i, o, a, b), o, a, b, eh, el,
             (o[1] && b == 32'd0) ? 1 : 32, 1'b1);
    end

    // mthi and mtlo together, then mtlo alone
    @(negedge clk);
    EX_rd1 = 32'hDEAD_BEEF; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo hi", hi, 32'hDEAD_BEEF);
    chk("mthi_mtlo lo", lo, 32'hDEAD_BEEF);
    EX_rd1 = 32'h1234_5678; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_only lo", lo, 32'h1234_5678);
    chk("mtlo_only hi", hi, 32'hDEAD_BEEF);

    // start and mthi on the same edge: start wins
    op = 2'd1; EX_rd1 = 32'd5; EX_rd2 = 32'd7; start = 1'b1; mthi = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("start_mthi hi_not_written", hi, 32'hDEAD_BEEF);
    wait_done(cyc, nb, 1'b0);
    chk("start_mthi latency", cyc, 32);
    chk("start_mthi hi", hi, 32'd0);
    chk("start_mthi lo", lo, 32'd35);

    // start and mthi during RUN are ignored
    @(negedge clk);
    op = 2'd1; EX_rd1 = 32'd2; EX_rd2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    op = 2'd3; EX_rd1 = 32'h0000_AAAA; EX_rd2 = 32'd9; start = 1'b1; mthi = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("run_ignore hi_mid", hi, 32'd0);
    wait_done(cyc, nb, 1'b0);
    chk("run_ignore latency", cyc, 28);
    chk("run_ignore hi", hi, 32'd0);
    chk("run_ignore lo", lo, 32'd6);

    // Reset in the middle of RUN aborts with no done pulse
    @(negedge clk);
    EX_rd1 = 32'h0000_1111; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    op = 2'd1; EX_rd1 = 32'hFFFF_FFFF; EX_rd2 = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort busy_before", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no_done_pulse", ndone, 0);

    // Back-to-back: start during DONE gives the next result 32 cycles later
    op = 2'd1; EX_rd1 = 32'd3; EX_rd2 = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, nb, 1'b0);
    chk("b2b first lo", lo, 32'd12);
    op = 2'd0; EX_rd1 = 32'hFFFF_FFFD; EX_rd2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b no_gap busy", busy, 1'b1);
    wait_done(cyc, nb, 1'b0);
    chk("b2b latency", cyc, 32);
    chk("b2b busy_cycles", nb, 32);
    chk("b2b hi", hi, 32'hFFFF_FFFF);
    chk("b2b lo", lo, 32'hFFFF_FFEB);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
